// File: rtl/hazard_stall_unit_if.sv
// Hazard unit bundle: ID/EX/WB hazard inputs and stall, flush and MDU outputs.
// The slave modport is the hazard unit; the master modport is the pipeline side.
interface hazard_stall_unit_if;
    logic       ID_valid;
    logic [2:0] ID_FwdRisk;
    logic [4:0] ID_rs1;
    logic [4:0] ID_rs2;
    logic [4:0] ID_rd;
    logic       ID_is_mdu;
    logic [2:0] EX_FwdRisk;
    logic [4:0] EX_rd;
    logic       EX_is_load;
    logic       EX_branch_taken;
    logic       WB_port_free;
    logic       Stall_IF;
    logic       Stall_ID;
    logic       Flush_ID;
    logic       Bubble_EX;
    logic       MDU_start;
    logic       MDU_busy;
    logic       MDU_wb_valid;
    logic [4:0] MDU_wb_rd;

    modport slave (
        input  ID_valid, ID_FwdRisk, ID_rs1, ID_rs2, ID_rd, ID_is_mdu,
        input  EX_FwdRisk, EX_rd, EX_is_load, EX_branch_taken, WB_port_free,
        output Stall_IF, Stall_ID, Flush_ID, Bubble_EX,
        output MDU_start, MDU_busy, MDU_wb_valid, MDU_wb_rd
    );

    modport master (
        output ID_valid, ID_FwdRisk, ID_rs1, ID_rs2, ID_rd, ID_is_mdu,
        output EX_FwdRisk, EX_rd, EX_is_load, EX_branch_taken, WB_port_free,
        input  Stall_IF, Stall_ID, Flush_ID, Bubble_EX,
        input  MDU_start, MDU_busy, MDU_wb_valid, MDU_wb_rd
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use and single-outstanding MDU hazard controller: stall/flush/bubble generation,
// MDU issue, latency tracking and writeback-port arbitration. Stall/flush outputs are combinational.
module hazard_stall_unit #(
    parameter int MDU_LATENCY = 32,
    parameter int CNT_W       = 6
) (
    input  logic               clk,
    input  logic               rst,
    hazard_stall_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       pend_rd_q, pend_rd_d;

    logic use_a, use_b, busy, load_use, mdu_raw, mdu_waw, mdu_struct, hz, issue, wb_vld;

    assign use_a = bus.ID_valid & bus.ID_FwdRisk[0] & (bus.ID_rs1 != 5'd0);
    assign use_b = bus.ID_valid & bus.ID_FwdRisk[1] & (bus.ID_rs2 != 5'd0);
    assign busy  = (state_q != IDLE);

    assign load_use = bus.EX_is_load & bus.EX_FwdRisk[2] & (bus.EX_rd != 5'd0) &
                      ((use_a & (bus.ID_rs1 == bus.EX_rd)) | (use_b & (bus.ID_rs2 == bus.EX_rd)));
    // The scoreboard stays armed through the DONE/commit cycle; release comes once back in IDLE.
    assign mdu_raw    = busy & ((use_a & (bus.ID_rs1 == pend_rd_q)) | (use_b & (bus.ID_rs2 == pend_rd_q)));
    assign mdu_waw    = busy & bus.ID_valid & bus.ID_FwdRisk[2] & (bus.ID_rd == pend_rd_q);
    assign mdu_struct = busy & bus.ID_valid & bus.ID_is_mdu;
    assign hz         = load_use | mdu_raw | mdu_waw | mdu_struct;

    assign issue = bus.ID_valid & bus.ID_is_mdu & ~hz & ~bus.EX_branch_taken & (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_rd_d = pend_rd_q;
        wb_vld    = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d   = BUSY;
                    cnt_d     = CNT_INIT;
                    pend_rd_d = bus.ID_FwdRisk[2] ? bus.ID_rd : 5'd0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A zero destination still drains the op but never claims the port.
                wb_vld = bus.WB_port_free & (pend_rd_q != 5'd0);
                if (bus.WB_port_free) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_rd_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_rd_q <= pend_rd_d;
        end
    end

    // Reset masks every output, including the registered ones, during the reset cycle itself.
    assign bus.Stall_IF     = ~rst & ~bus.EX_branch_taken & hz;
    assign bus.Stall_ID     = ~rst & ~bus.EX_branch_taken & hz;
    assign bus.Flush_ID     = ~rst & bus.EX_branch_taken;
    assign bus.Bubble_EX    = ~rst & (bus.EX_branch_taken | hz);
    assign bus.MDU_start    = ~rst & issue;
    assign bus.MDU_busy     = ~rst & busy;
    assign bus.MDU_wb_valid = ~rst & wb_vld;
    assign bus.MDU_wb_rd    = rst ? 5'd0 : pend_rd_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with MDU_LATENCY=4; output vector order is
// {Stall_IF, Stall_ID, Flush_ID, Bubble_EX, MDU_start, MDU_busy, MDU_wb_valid}.
module tb_hazard_stall_unit;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    hazard_stall_unit_if hif ();

    hazard_stall_unit #(.MDU_LATENCY(4), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [2:0] risk, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic mdu);
        hif.ID_valid   = v;
        hif.ID_FwdRisk = risk;
        hif.ID_rs1     = rs1;
        hif.ID_rs2     = rs2;
        hif.ID_rd      = rd;
        hif.ID_is_mdu  = mdu;
    endtask

    task automatic set_ex(input logic ld, input logic [2:0] risk, input logic [4:0] rd, input logic br);
        hif.EX_is_load      = ld;
        hif.EX_FwdRisk      = risk;
        hif.EX_rd           = rd;
        hif.EX_branch_taken = br;
    endtask

    task automatic chk(input string tag, input logic [6:0] exp_v);
        logic [6:0] obs;
        obs = {hif.Stall_IF, hif.Stall_ID, hif.Flush_ID, hif.Bubble_EX,
               hif.MDU_start, hif.MDU_busy, hif.MDU_wb_valid};
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [4:0] exp_rd);
        tests++;
        assert (hif.MDU_wb_rd === exp_rd) else begin
            fails++;
            $error("FAIL %s: observed rd %0d, expected rd %0d", tag, hif.MDU_wb_rd, exp_rd);
        end
    endtask

    initial begin
        // Reset with a load-use hazard and a mul in ID: every output must stay low.
        rst = 1'b1;
        hif.WB_port_free = 1'b1;
        set_ex(1'b1, 3'b100, 5'd5, 1'b0);
        set_id(1'b1, 3'b101, 5'd5, 5'd0, 5'd6, 1'b1);
        tick();
        tick();
        chk("rst_outputs", 7'b0000000);
        chk_rd("rst_rd", 5'd0);

        // Load-use on rs1: one-cycle stall then release once EX holds the bubble.
        tick();
        rst = 1'b0;
        set_id(1'b1, 3'b101, 5'd5, 5'd0, 5'd6, 1'b0);
        #1 chk("lu_rs1", 7'b1101000);
        tick();
        set_ex(1'b0, 3'b000, 5'd0, 1'b0);
        #1 chk("lu_release", 7'b0000000);
        tick();
        set_ex(1'b1, 3'b100, 5'd0, 1'b0);
        set_id(1'b1, 3'b101, 5'd0, 5'd0, 5'd6, 1'b0);
        #1 chk("lu_rd0", 7'b0000000);
        tick();
        set_ex(1'b1, 3'b100, 5'd5, 1'b0);
        set_id(1'b1, 3'b110, 5'd1, 5'd5, 5'd6, 1'b0);
        #1 chk("lu_rs2", 7'b1101000);
        tick();
        set_id(1'b1, 3'b100, 5'd1, 5'd5, 5'd6, 1'b0);
        #1 chk("lu_rs2_unused", 7'b0000000);

        // Latency run: start at cycle 0, busy 1..4, commit at cycle 4, idle at 5.
        tick();
        set_ex(1'b0, 3'b000, 5'd0, 1'b0);
        set_id(1'b1, 3'b111, 5'd1, 5'd2, 5'd7, 1'b1);
        #1 chk("lat_start", 7'b0000100);
        tick();
        set_id(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0);
        #1 chk("lat_c1", 7'b0000010);
        chk_rd("lat_rd_c1", 5'd7);
        tick();
        set_id(1'b1, 3'b101, 5'd3, 5'd0, 5'd9, 1'b0);
        #1 chk("lat_unrelated", 7'b0000010);
        tick();
        set_id(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0);
        #1 chk("lat_c3", 7'b0000010);
        tick();
        chk("lat_commit", 7'b0000011);
        chk_rd("lat_commit_rd", 5'd7);
        tick();
        chk("lat_idle", 7'b0000000);

        // RAW (rs2=7), WAW (rd=7), structural (second mul): stall through commit.
        for (int k = 0; k < 3; k++) begin
            tick();
            set_id(1'b1, 3'b111, 5'd1, 5'd2, 5'd7, 1'b1);
            #1 chk("hz_start", 7'b0000100);
            for (int c = 1; c <= 4; c++) begin
                tick();
                case (k)
                    0:       set_id(1'b1, 3'b011, 5'd1, 5'd7, 5'd0, 1'b0);
                    1:       set_id(1'b1, 3'b100, 5'd1, 5'd2, 5'd7, 1'b0);
                    default: set_id(1'b1, 3'b111, 5'd1, 5'd2, 5'd8, 1'b1);
                endcase
                #1 chk($sformatf("hz%0d_c%0d", k, c), (c == 4) ? 7'b1101011 : 7'b1101010);
            end
            tick();
            chk($sformatf("hz%0d_release", k), (k == 2) ? 7'b0000100 : 7'b0000000);
        end

        // The released second mul (rd=8) runs into a busy writeback port.
        tick();
        set_id(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0);
        hif.WB_port_free = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1 chk($sformatf("pc_busy_c%0d", c), 7'b0000010);
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("pc_hold_%0d", c), 7'b0000010);
            chk_rd($sformatf("pc_hold_rd_%0d", c), 5'd8);
            tick();
        end
        hif.WB_port_free = 1'b1;
        #1 chk("pc_commit", 7'b0000011);
        chk_rd("pc_commit_rd", 5'd8);
        tick();
        chk("pc_idle", 7'b0000000);

        // Branch beats load-use and blocks an MDU issue in the same cycle.
        tick();
        set_ex(1'b1, 3'b100, 5'd5, 1'b1);
        set_id(1'b1, 3'b101, 5'd5, 5'd0, 5'd6, 1'b1);
        #1 chk("br_prio", 7'b0011000);
        tick();
        set_ex(1'b0, 3'b000, 5'd0, 1'b0);
        set_id(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0);
        #1 chk("br_no_launch", 7'b0000000);

        // Reset mid-op at cnt=2; a branch during BUSY must not cancel the op first.
        tick();
        set_id(1'b1, 3'b111, 5'd1, 5'd2, 5'd7, 1'b1);
        #1 chk("rm_start", 7'b0000100);
        tick();
        set_id(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0);
        set_ex(1'b0, 3'b000, 5'd0, 1'b1);
        #1 chk("rm_branch_busy", 7'b0011010);
        tick();
        set_ex(1'b0, 3'b000, 5'd0, 1'b0);
        #1 chk("rm_cnt2", 7'b0000010);
        rst = 1'b1;
        #1 chk("rm_in_reset", 7'b0000000);
        chk_rd("rm_in_reset_rd", 5'd0);
        tick();
        rst = 1'b0;
        #1 chk("rm_after", 7'b0000000);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("rm_no_wb_%0d", c), 7'b0000000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
